div_pipelined_ext: RTL
======================

Name: div_pipelined_ext

Overview:
- Fully pipelined restoring integer divider producing quotient and remainder.
- Parametrised width; signed or unsigned mode.
- Valid sideband, global pipeline enable, divide-by-zero and signed-overflow flags.
- Accepts one operation per enabled cycle.
- Sits in the math pipeline library alongside the pipelined multiplier and identity delay line.
- Consumers align other datapaths to it with a delay line of length LAT.

Parameters:
- DW, 16: operand width; dividend, divisor, quotient and remainder are all DW bits.
- SIGNED, 1: 1 = two's-complement truncating division; 0 = unsigned.
- LAT, DW+2 (derived, not overridable): cycles from input acceptance to output.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  pipeline enable; 0 freezes every stage.
- in_valid  in  1  input operands valid this cycle.
- dividend  in  DW  numerator.
- divisor  in  DW  denominator.
- out_valid  out  1  result valid.
- quotient  out  DW  result quotient.
- remainder  out  DW  result remainder.
- dbz  out  1  divide-by-zero flag for this result.
- ovf  out  1  signed overflow flag for this result (SIGNED=1 only).

Behaviour:
Reset and enable:
- Single clock clk. Reset rst_n is synchronous, active-low, and overrides en.
- Reset clears all stage valid bits. out_valid, quotient, remainder, dbz and ovf read 0 the cycle after reset is sampled low.
- Internal data registers need not be cleared.
- en=0: no register changes, including outputs, and in_valid/operands are ignored. en=1: every stage advances one step.
- Input is accepted when en=1 and in_valid=1. Bubbles (in_valid=0) propagate as out_valid=0.

Pipeline structure:
- Stage 0 registers:
  - |dividend| and |divisor| (absolute value only when SIGNED=1);
  - quotient sign = sign(dividend) XOR sign(divisor);
  - remainder sign = sign(dividend);
  - dbz = (divisor==0);
  - ovf = SIGNED & (dividend==100..0) & (divisor==all ones);
  - valid.
- Stages 1..DW: one restoring step each, MSB first.
  - Partial remainder is DW+1 bits; trial subtract of the divisor.
  - Quotient bit = 1 when the trial is non-negative, otherwise the partial remainder is restored.
  - Signs, flags and valid travel alongside.
- Final stage DW+1 applies sign correction and special cases, then registers the outputs.
  - Result for an input accepted at enabled cycle k appears at enabled cycle k+LAT.
- Absolute value of the most negative number is taken as unsigned DW-bit magnitude. No extra width is needed; the special case is handled by ovf.

Arithmetic rules:
- Truncation toward zero. Remainder takes the sign of the dividend.
- dividend = quotient*divisor + remainder holds in DW-bit arithmetic for every non-flagged case.
- dbz=1: quotient = all ones; remainder = dividend unchanged; ovf=0.
- ovf=1: quotient = dividend (most negative); remainder = 0.
- dbz and ovf are mutually exclusive. Flags are meaningful only with out_valid=1 and read 0 otherwise.
- SIGNED=0: no sign handling, ovf constantly 0.

Throughput and boundaries:
- Throughput is one result per enabled cycle with no backpressure. The downstream consumer must accept every out_valid or deassert en.
- Reset mid-operation drops all in-flight operations; no partial result ever emerges.
- en toggling mid-flight preserves ordering and data exactly.

Test Plan:
- DW=8, SIGNED=0, en=1: dividend 100, divisor 7 at cycle 0 -> out_valid, quotient 14, remainder 2 at cycle 10, out_valid=0 on cycles 1-9 and 11.
- DW=8, SIGNED=1: -7/2 -> q=-3 (0xFD), r=-1 (0xFF); 7/-2 -> q=-3, r=1; -7/-2 -> q=3, r=-1. Issue back-to-back, expect three consecutive valid results.
- DW=8, SIGNED=1: 55/0 -> dbz=1, q=0xFF, r=55, ovf=0; -128/-1 -> ovf=1, q=0x80, r=0, dbz=0.
- Random stream of 1000 operands with random in_valid and en: results match the reference model in order. Each result appears exactly LAT enabled cycles after acceptance; outputs hold while en=0.
- Load 5 operations, assert rst_n=0 for one cycle mid-flight -> outputs 0 next cycle and no out_valid ever appears for the dropped operations. A new op after reset yields the correct result after LAT cycles.
- DW=16, SIGNED=0: 65535/1 -> q=65535, r=0; 1/65535 -> q=0, r=1 at cycle 18.

Source files
------------

// File: rtl/div_pipelined_ext_if.sv
// rtl/div_pipelined_ext_if.sv - Operand/result bundle for the pipelined divider
// Purpose: groups the operand handshake and result signals of div_pipelined_ext.
// Signals:
//   in_valid  - operands valid this cycle (master -> slave)
//   dividend  - numerator, DW bits (master -> slave)
//   divisor   - denominator, DW bits (master -> slave)
//   out_valid - result valid (slave -> master)
//   quotient  - result quotient, DW bits (slave -> master)
//   remainder - result remainder, DW bits (slave -> master)
//   dbz       - divide-by-zero flag for this result (slave -> master)
//   ovf       - signed overflow flag for this result (slave -> master)
interface div_pipelined_ext_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          out_valid;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          dbz;
  logic          ovf;

  modport master (
    output in_valid, dividend, divisor,
    input  out_valid, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor,
    output out_valid, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/div_pipelined_ext.sv
// rtl/div_pipelined_ext.sv - Fully pipelined restoring integer divider
// Purpose: one quotient/remainder per enabled cycle, result DW+2 enabled
//   cycles after acceptance; signed (truncating) or unsigned mode.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset, overrides en
//   en    - pipeline enable; 0 freezes every stage and the outputs
//   bus   - slave side of div_pipelined_ext_if (operands in, results out)
module div_pipelined_ext #(
  parameter int DW     = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  div_pipelined_ext_if.slave bus
);

  localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  // Stage s holds the state after s restoring steps. aq holds the not yet
  // consumed dividend bits in its upper part and the quotient bits produced
  // so far in its lower part; after DW steps it is the quotient magnitude.
  // A partial remainder always ends below the divisor, so DW bits store it;
  // only the shifted trial value needs DW+1 bits.
  logic [DW-1:0] p_q  [0:DW];
  logic [DW-1:0] p_d  [0:DW];
  logic [DW-1:0] aq_q [0:DW];
  logic [DW-1:0] aq_d [0:DW];
  logic [DW-1:0] d_q  [0:DW-1];
  logic [DW-1:0] d_d  [0:DW-1];

  // Per-stage sideband, bit s belongs to stage s.
  logic [DW:0] qs_q, qs_d;   // quotient sign
  logic [DW:0] rs_q, rs_d;   // remainder sign
  logic [DW:0] fz_q, fz_d;   // divide by zero
  logic [DW:0] fo_q, fo_d;   // signed overflow
  logic [DW:0] v_q,  v_d;    // stage valid

  logic [DW:0]   shift_w;
  logic [DW:0]   trial_w;
  logic          dvd_neg;
  logic          dvs_neg;
  logic [DW-1:0] q_fix;
  logic [DW-1:0] r_fix;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] quotient_q,  quotient_d;
  logic [DW-1:0] remainder_q, remainder_d;
  logic          dbz_q,       dbz_d;
  logic          ovf_q,       ovf_d;

  always_comb begin
    dvd_neg = SIGNED && bus.dividend[DW-1];
    dvs_neg = SIGNED && bus.divisor[DW-1];

    // Stage 0: magnitudes. The most negative value negates to itself, which
    // read as unsigned is exactly its magnitude.
    p_d[0]  = '0;
    aq_d[0] = dvd_neg ? -bus.dividend : bus.dividend;
    d_d[0]  = dvs_neg ? -bus.divisor  : bus.divisor;

    shift_w = '0;
    trial_w = '0;
    for (int s = 1; s <= DW; s++) begin
      shift_w = {p_q[s-1], aq_q[s-1][DW-1]};
      trial_w = shift_w - {1'b0, d_q[s-1]};
      if (trial_w[DW]) begin
        p_d[s]  = shift_w[DW-1:0];
        aq_d[s] = {aq_q[s-1][DW-2:0], 1'b0};
      end else begin
        p_d[s]  = trial_w[DW-1:0];
        aq_d[s] = {aq_q[s-1][DW-2:0], 1'b1};
      end
    end
    for (int s = 1; s < DW; s++) begin
      d_d[s] = d_q[s-1];
    end

    qs_d = {qs_q[DW-1:0], dvd_neg ^ dvs_neg};
    rs_d = {rs_q[DW-1:0], dvd_neg};
    fz_d = {fz_q[DW-1:0], bus.divisor == '0};
    fo_d = {fo_q[DW-1:0], SIGNED && (bus.dividend == MOST_NEG) && (bus.divisor == '1)};
    v_d  = {v_q[DW-1:0], bus.in_valid};
  end

  // Final stage: sign correction and special cases. With a zero divisor
  // every trial succeeds, so the remainder path already rebuilds the
  // dividend; only the quotient needs forcing.
  always_comb begin
    q_fix = qs_q[DW] ? -aq_q[DW] : aq_q[DW];
    r_fix = rs_q[DW] ? -p_q[DW]  : p_q[DW];

    out_valid_d = v_q[DW];
    quotient_d  = '0;
    remainder_d = '0;
    dbz_d       = 1'b0;
    ovf_d       = 1'b0;
    if (v_q[DW]) begin
      quotient_d  = q_fix;
      remainder_d = r_fix;
      dbz_d       = fz_q[DW];
      ovf_d       = fo_q[DW];
      if (fz_q[DW]) begin
        quotient_d = '1;
      end
      if (fo_q[DW]) begin
        quotient_d  = MOST_NEG;
        remainder_d = '0;
      end
    end
  end

  // Control and outputs: cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  // Datapath: never read without a matching valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int s = 0; s <= DW; s++) begin
        p_q[s]  <= p_d[s];
        aq_q[s] <= aq_d[s];
      end
      for (int s = 0; s < DW; s++) begin
        d_q[s] <= d_d[s];
      end
      qs_q <= qs_d;
      rs_q <= rs_d;
      fz_q <= fz_d;
      fo_q <= fo_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dbz       = dbz_q;
  assign bus.ovf       = ovf_q;

endmodule
